// File: rtl/lampball_pkg.sv
// lampball_pkg: shared types and constants for the 8-lamp handball sequencer.
//   - state_t  : game sequencer states
//   - side_t   : identifies a player / board end (left = bit7, right = bit0)
//   - SEL_*    : shift register mode codes
//   - LAMP_* / WIN_*_PATTERN : lamp images loaded into the shift register
package lampball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_MOVE,
        ST_POINT,
        ST_OVER
    } state_t;

    // Encoding doubles as the index into the two-bit button/score vectors.
    typedef enum logic {
        SIDE_LEFT  = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    localparam logic [7:0] LAMP_DARK     = 8'h00;
    localparam logic [7:0] LAMP_LEFT     = 8'h80;
    localparam logic [7:0] LAMP_RIGHT    = 8'h01;
    localparam logic [7:0] WIN_L_PATTERN = 8'hF0;
    localparam logic [7:0] WIN_R_PATTERN = 8'h0F;

    function automatic side_t other_side(input side_t s);
        return (s == SIDE_LEFT) ? SIDE_RIGHT : SIDE_LEFT;
    endfunction

    // Lamp that is lit when the ball sits at the given player's end.
    function automatic logic [7:0] end_lamp(input side_t s);
        return (s == SIDE_LEFT) ? LAMP_LEFT : LAMP_RIGHT;
    endfunction

endpackage

// File: rtl/lampball_ctrl_btn_edge.sv
// btn_edge: registered rising-edge detector for one debounced button.
//   clk   : system clock
//   srst  : synchronous active-high clear (history and output)
//   btn   : button level, already synchronous to clk
//   press : one-cycle pulse, the cycle after btn was first seen high
module btn_edge (
    input  logic clk,
    input  logic srst,
    input  logic btn,
    output logic press
);

    logic btn_prev_reg;
    logic press_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            btn_prev_reg <= 1'b0;
            press_reg    <= 1'b0;
        end else begin
            btn_prev_reg <= btn;
            press_reg    <= btn & ~btn_prev_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/lampball_ctrl.sv
// lampball_ctrl: game sequencer for the 8-lamp handball board.
//   CK, CLEAR      : clock, synchronous active-high reset
//   TICK           : ball-speed strobe (pulses >= 4 cycles apart)
//   START          : starts a game from IDLE or OVER
//   BTN_L, BTN_R   : debounced player buttons (levels)
//   SROUT          : shift register contents (bit7 = left lamp)
//   SEL, SRIN      : shift register mode and parallel-load value
//   SIL, SIR       : serial inputs, always 0 so shifted-out lamps go dark
//   SCORE_L/R      : player scores, saturating at WIN_SCORE
//   GAME_OVER      : high while a finished game is displayed
module lampball_ctrl
    import lampball_pkg::*;
#(
    parameter int WIN_SCORE = 9,
    parameter int SW        = 4
) (
    input  logic          CK,
    input  logic          CLEAR,
    input  logic          TICK,
    input  logic          START,
    input  logic          BTN_L,
    input  logic          BTN_R,
    input  logic [7:0]    SROUT,
    output logic [1:0]    SEL,
    output logic [7:0]    SRIN,
    output logic          SIL,
    output logic          SIR,
    output logic [SW-1:0] SCORE_L,
    output logic [SW-1:0] SCORE_R,
    output logic          GAME_OVER
);

    localparam logic [SW-1:0] WIN = SW'(WIN_SCORE);

    // Button edge detectors, indexed by side_t (0 = left, 1 = right).
    logic [1:0] btn_bus;
    logic [1:0] press;

    assign btn_bus = {BTN_R, BTN_L};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_edge u_edge (
                .clk   (CK),
                .srst  (CLEAR),
                .btn   (btn_bus[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // The rally direction is held as the receiving side: receiver right
    // means the ball travels toward bit0.
    state_t               state_reg,     state_next;
    side_t                server_reg,    server_next;
    side_t                rcv_reg,       rcv_next;
    side_t                scorer_reg,    scorer_next;
    logic [1:0][SW-1:0]   score_reg,     score_next;
    logic [1:0]           sel_reg,       sel_next;
    logic [7:0]           srin_reg,      srin_next;
    logic                 game_over_reg, game_over_next;

    logic                 shift_now;
    logic [SW-1:0]        score_inc;

    always_ff @(posedge CK) begin
        if (CLEAR) begin
            state_reg     <= ST_IDLE;
            server_reg    <= SIDE_LEFT;
            rcv_reg       <= SIDE_RIGHT;
            scorer_reg    <= SIDE_LEFT;
            score_reg     <= '0;
            sel_reg       <= SEL_LOAD;
            srin_reg      <= LAMP_DARK;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            server_reg    <= server_next;
            rcv_reg       <= rcv_next;
            scorer_reg    <= scorer_next;
            score_reg     <= score_next;
            sel_reg       <= sel_next;
            srin_reg      <= srin_next;
            game_over_reg <= game_over_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next  = state_reg;
        server_next = server_reg;
        rcv_next    = rcv_reg;
        scorer_next = scorer_reg;
        score_next  = score_reg;
        shift_now   = 1'b0;
        score_inc   = score_reg[scorer_reg];

        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    state_next = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (press[server_reg]) begin
                    state_next = ST_MOVE;
                    rcv_next   = other_side(server_reg);
                end
            end

            ST_MOVE: begin
                if (SROUT == LAMP_DARK) begin
                    // Ball lost from the board: abandon the rally.
                    state_next = ST_IDLE;
                end else if (press[rcv_reg]) begin
                    // A press outranks a coincident TICK.
                    if (SROUT == end_lamp(rcv_reg)) begin
                        rcv_next = other_side(rcv_reg);
                    end else begin
                        scorer_next = other_side(rcv_reg);
                        state_next  = ST_POINT;
                    end
                end else if (TICK) begin
                    if (SROUT == end_lamp(rcv_reg)) begin
                        scorer_next = other_side(rcv_reg);
                        state_next  = ST_POINT;
                    end else begin
                        shift_now = 1'b1;
                    end
                end
            end

            ST_POINT: begin
                if (score_reg[scorer_reg] < WIN) begin
                    score_inc = score_reg[scorer_reg] + SW'(1);
                end
                score_next[scorer_reg] = score_inc;
                server_next            = other_side(scorer_reg);
                state_next             = (score_inc == WIN) ? ST_OVER : ST_SERVE;
            end

            ST_OVER: begin
                if (START) begin
                    score_next  = '0;
                    server_next = SIDE_LEFT;
                    state_next  = ST_SERVE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    always_comb begin
        sel_next       = SEL_LOAD;
        srin_next      = LAMP_DARK;
        game_over_next = 1'b0;

        case (state_next)
            ST_SERVE: begin
                srin_next = end_lamp(server_next);
            end
            ST_MOVE: begin
                if (shift_now) begin
                    sel_next = (rcv_reg == SIDE_RIGHT) ? SEL_RIGHT : SEL_LEFT;
                end else begin
                    sel_next = SEL_HOLD;
                end
            end
            ST_OVER: begin
                game_over_next = 1'b1;
                srin_next      = (score_next[SIDE_LEFT] == WIN) ? WIN_L_PATTERN
                                                                : WIN_R_PATTERN;
            end
            default: begin
                srin_next = LAMP_DARK;
            end
        endcase
    end

    assign SEL       = sel_reg;
    assign SRIN      = srin_reg;
    assign SIL       = 1'b0;
    assign SIR       = 1'b0;
    assign SCORE_L   = score_reg[SIDE_LEFT];
    assign SCORE_R   = score_reg[SIDE_RIGHT];
    assign GAME_OVER = game_over_reg;

endmodule

// File: tb/tb_lampball_ctrl.sv
// tb_lampball_ctrl: drives the sequencer against a behavioural board model
// (the shift register) and a game-level reference model.
module tb_lampball_ctrl;

    localparam int WIN = 2;

    // Action kinds
    localparam int A_START   = 0;
    localparam int A_PRESS   = 1;
    localparam int A_TICK    = 2;
    localparam int A_PRTICK  = 3;
    localparam int A_CORRUPT = 4;
    localparam int A_CLEAR   = 5;

    // Model phases
    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_RALLY = 2;
    localparam int P_OVER  = 3;

    logic       CK    = 1'b0;
    logic       CLEAR = 1'b1;
    logic       TICK  = 1'b0;
    logic       START = 1'b0;
    logic       BTN_L = 1'b0;
    logic       BTN_R = 1'b0;
    logic [7:0] SROUT;
    logic [1:0] SEL;
    logic [7:0] SRIN;
    logic       SIL;
    logic       SIR;
    logic [3:0] SCORE_L;
    logic [3:0] SCORE_R;
    logic       GAME_OVER;

    lampball_ctrl #(.WIN_SCORE(WIN), .SW(4)) dut (
        .CK        (CK),
        .CLEAR     (CLEAR),
        .TICK      (TICK),
        .START     (START),
        .BTN_L     (BTN_L),
        .BTN_R     (BTN_R),
        .SROUT     (SROUT),
        .SEL       (SEL),
        .SRIN      (SRIN),
        .SIL       (SIL),
        .SIR       (SIR),
        .SCORE_L   (SCORE_L),
        .SCORE_R   (SCORE_R),
        .GAME_OVER (GAME_OVER)
    );

    always #5 CK = ~CK;

    // Board: the physical shift register, plus counters of shift cycles.
    logic [7:0] board   = 8'h00;
    logic       corrupt = 1'b0;
    int         n_right = 0;
    int         n_left  = 0;

    always @(posedge CK) begin
        if (corrupt)             board <= 8'h00;
        else if (SEL == 2'b01)   board <= {SIR, board[7:1]};
        else if (SEL == 2'b10)   board <= {board[6:0], SIL};
        else if (SEL == 2'b11)   board <= SRIN;
        if (SEL == 2'b01) n_right <= n_right + 1;
        if (SEL == 2'b10) n_left  <= n_left + 1;
    end

    assign SROUT = board;

    // Game-level reference model. Sides: 0 = left, 1 = right.
    // Ball position: 7 = left end lamp, 0 = right end lamp.
    int m_phase  = P_IDLE;
    int m_score[2] = '{0, 0};
    int m_server = 0;
    int m_rcv    = 1;
    int m_pos    = 0;
    int m_winner = 0;
    int exp_r    = 0;
    int exp_l    = 0;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int end_pos(input int side);
        return (side == 0) ? 7 : 0;
    endfunction

    function automatic int exp_image();
        case (m_phase)
            P_SERVE: return (m_server == 0) ? 'h80 : 'h01;
            P_RALLY: return 1 << m_pos;
            P_OVER:  return (m_winner == 0) ? 'hF0 : 'h0F;
            default: return 0;
        endcase
    endfunction

    task automatic m_point(input int p);
        if (m_score[p] < WIN) m_score[p]++;
        m_server = 1 - p;
        if (m_score[p] == WIN) begin
            m_phase  = P_OVER;
            m_winner = p;
        end else begin
            m_phase = P_SERVE;
        end
    endtask

    task automatic m_start();
        if (m_phase == P_IDLE) begin
            m_phase = P_SERVE;
        end else if (m_phase == P_OVER) begin
            m_score  = '{0, 0};
            m_server = 0;
            m_phase  = P_SERVE;
        end
    endtask

    // handled = 1 when the press changed the game, so a coincident tick is moot.
    task automatic m_press(input int side, output int handled);
        handled = 0;
        if (m_phase == P_SERVE && side == m_server) begin
            m_phase = P_RALLY;
            m_pos   = end_pos(m_server);
            m_rcv   = 1 - m_server;
            handled = 1;
        end else if (m_phase == P_RALLY && side == m_rcv) begin
            if (m_pos == end_pos(m_rcv)) m_rcv = 1 - m_rcv;
            else                         m_point(1 - m_rcv);
            handled = 1;
        end
    endtask

    task automatic m_tick();
        if (m_phase == P_RALLY) begin
            if (m_pos == end_pos(m_rcv)) begin
                m_point(1 - m_rcv);
            end else if (m_rcv == 1) begin
                m_pos--;
                exp_r = 1;
            end else begin
                m_pos++;
                exp_l = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    task automatic set_btn(input int side, input logic v);
        if (side == 0) BTN_L = v;
        else           BTN_R = v;
    endtask

    task automatic verify(input string tag, input int r0, input int l0);
        check({tag, "_sel"}, 32'(SEL), (m_phase == P_RALLY) ? 0 : 3);
        if (m_phase != P_RALLY) check({tag, "_srin"}, 32'(SRIN), exp_image());
        check({tag, "_srout"}, 32'(SROUT), exp_image());
        check({tag, "_score_l"}, 32'(SCORE_L), m_score[0]);
        check({tag, "_score_r"}, 32'(SCORE_R), m_score[1]);
        check({tag, "_game_over"}, 32'(GAME_OVER), (m_phase == P_OVER) ? 1 : 0);
        check({tag, "_shifts_r"}, n_right - r0, exp_r);
        check({tag, "_shifts_l"}, n_left - l0, exp_l);
    endtask

    task automatic do_action(input int kind, input int side);
        int    r0;
        int    l0;
        int    handled;
        string tag;
        r0    = n_right;
        l0    = n_left;
        exp_r = 0;
        exp_l = 0;
        case (kind)
            A_START:   tag = "start";
            A_PRESS:   tag = (side == 0) ? "press_l" : "press_r";
            A_TICK:    tag = "tick";
            A_PRTICK:  tag = (side == 0) ? "prtick_l" : "prtick_r";
            A_CORRUPT: tag = "corrupt";
            default:   tag = "clear";
        endcase
        case (kind)
            A_START: begin
                m_start();
                START = 1'b1; cyc(); START = 1'b0;
            end
            A_PRESS: begin
                m_press(side, handled);
                set_btn(side, 1'b1); cyc(); cyc(); set_btn(side, 1'b0);
            end
            A_TICK: begin
                m_tick();
                TICK = 1'b1; cyc(); TICK = 1'b0;
            end
            A_PRTICK: begin
                // Button rises one cycle ahead of TICK so the registered
                // press pulse and TICK are seen at the same edge.
                m_press(side, handled);
                if (handled == 0) m_tick();
                set_btn(side, 1'b1); cyc();
                TICK = 1'b1; cyc(); TICK = 1'b0; cyc();
                set_btn(side, 1'b0);
            end
            A_CORRUPT: begin
                if (m_phase == P_RALLY) m_phase = P_IDLE;
                corrupt = 1'b1; cyc(); corrupt = 1'b0;
            end
            default: begin
                CLEAR = 1'b1; cyc(); CLEAR = 1'b0;
                @(negedge CK);
                check("clr_sel", 32'(SEL), 3);
                check("clr_srin", 32'(SRIN), 0);
                check("clr_score_l", 32'(SCORE_L), 0);
                check("clr_score_r", 32'(SCORE_R), 0);
                check("clr_game_over", 32'(GAME_OVER), 0);
                m_phase  = P_IDLE;
                m_score  = '{0, 0};
                m_server = 0;
                cyc();
            end
        endcase
        repeat (6) cyc();
        @(negedge CK);
        verify(tag, r0, l0);
        txn++;
        $display("txn %0d %s phase=%0d SEL=%b SRIN=%h SROUT=%h L=%0d R=%0d GO=%0b",
                 txn, tag, m_phase, SEL, SRIN, SROUT, SCORE_L, SCORE_R, GAME_OVER);
    endtask

    initial begin
        int kind;
        int roll;
        // Reset
        CLEAR = 1'b1;
        repeat (3) cyc();
        CLEAR = 1'b0;
        repeat (2) cyc();
        @(negedge CK);
        verify("reset", n_right, n_left);

        // Serve from the left, walk the ball to the right end, return it,
        // then let it travel back one lamp.
        do_action(A_START, 0);
        do_action(A_PRESS, 0);
        for (int i = 0; i < 7; i++) do_action(A_TICK, 0);
        do_action(A_PRESS, 1);
        do_action(A_TICK, 0);

        // Fresh game: right misses at its end, left scores, right serves.
        do_action(A_CLEAR, 0);
        do_action(A_START, 0);
        do_action(A_PRESS, 0);
        for (int i = 0; i < 8; i++) do_action(A_TICK, 0);
        do_action(A_PRESS, 1);
        for (int i = 0; i < 7; i++) do_action(A_TICK, 0);
        do_action(A_PRESS, 0);
        for (int i = 0; i < 4; i++) do_action(A_TICK, 0);
        // Ball at 8'h08 heading right: left press ignored, right press faults
        // and gives the winning point to the left.
        do_action(A_PRESS, 0);
        do_action(A_PRESS, 1);
        do_action(A_START, 0);

        // Coincident return and TICK at the right end.
        do_action(A_PRESS, 0);
        for (int i = 0; i < 7; i++) do_action(A_TICK, 0);
        do_action(A_PRTICK, 1);
        do_action(A_TICK, 0);
        do_action(A_TICK, 0);
        do_action(A_CLEAR, 0);

        // Corrupted board mid-rally.
        do_action(A_START, 0);
        do_action(A_PRESS, 0);
        do_action(A_TICK, 0);
        do_action(A_CORRUPT, 0);
        do_action(A_START, 0);

        // Randomised play.
        for (int i = 0; i < 300; i++) begin
            roll = int'($urandom_range(0, 99));
            if (roll < 45)      kind = A_TICK;
            else if (roll < 75) kind = A_PRESS;
            else if (roll < 87) kind = A_PRTICK;
            else if (roll < 96) kind = A_START;
            else if (roll < 98) kind = (m_phase == P_RALLY) ? A_CORRUPT : A_TICK;
            else                kind = A_CLEAR;
            do_action(kind, int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lampball_ctrl.md
Name: lampball_ctrl

Overview:
- Game sequencer for the 8-lamp handball board. Drives the bidirectional shift register's SEL/SRIN/SIL/SIR so a single lit lamp (the ball) travels between players.
- Reads the register's SROUT and two player buttons, and decides returns, misses and early-hit faults.
- Keeps both scores and flags game over.
- Sits between the button front end (synchronised, debounced) and the shift register / lamp drivers.

Parameters:
- WIN_SCORE, 9, points needed to win; range 1..15.
- SW, 4, score counter width.

Ports:
- CK, in, 1, system clock.
- CLEAR, in, 1, synchronous active-high reset.
- TICK, in, 1, one-cycle ball-speed strobe. Consecutive pulses are ≥4 CK cycles apart.
- START, in, 1, one-cycle pulse; starts a game from IDLE or OVER.
- BTN_L, in, 1, left player button: level, synchronous to CK, debounced.
- BTN_R, in, 1, right player button: same conditions as BTN_L.
- SROUT, in, 8, shift register contents. Bit7 = left-end lamp, bit0 = right-end lamp.
- SEL, out, 2, shift register mode: 00 hold, 01 right shift (toward bit0), 10 left shift (toward bit7), 11 parallel load.
- SRIN, out, 8, parallel-load value.
- SIL, out, 1, serial-in for left shift; constant 0.
- SIR, out, 1, serial-in for right shift; constant 0.
- SCORE_L, out, SW, left player score.
- SCORE_R, out, SW, right player score.
- GAME_OVER, out, 1, high in OVER.

Behaviour:
- All outputs are registered.
- Reset (CLEAR=1 at a CK edge), taking priority over everything:
  - state IDLE, SEL=11, SRIN=8'h00, SIL=SIR=0;
  - SCORE_L=SCORE_R=0, GAME_OVER=0, server=LEFT;
  - button edge detectors' history cleared.
- Button press = rising edge of BTN_x (internal edge detect). Held buttons never repeat.

States:
- IDLE: SEL=11, SRIN=8'h00 (lamps dark). START -> SERVE.
- SERVE: SEL=11, SRIN = 8'h80 if server=LEFT, 8'h01 if server=RIGHT.
  - Server's press -> MOVE with direction away from server; SEL=00 the next cycle.
  - Non-server presses are ignored.
- MOVE (direction dir, receiver = player at far end), on TICK:
  - If SROUT equals the receiver end lamp (8'h01 for dir=right, 8'h80 for dir=left): miss. Point to the non-receiver; -> POINT.
  - Otherwise SEL=01 (dir=right) or 10 (dir=left) for exactly one cycle, then 00.
- MOVE, receiver press:
  - SROUT == receiver end lamp: return. dir flips, no shift that cycle; the next TICK shifts away.
  - Otherwise: early-hit fault. Point to the non-receiver; -> POINT.
- MOVE, presses by the non-receiver are ignored.
- MOVE, receiver press and TICK in the same cycle: the press is evaluated first. A valid return suppresses the miss and the shift.
- MOVE, SROUT == 8'h00 (corrupt board): -> IDLE; scores unchanged.
- POINT (1 cycle):
  - increment the scorer's counter; SEL=11, SRIN=8'h00; server = loser of the point;
  - new score == WIN_SCORE -> OVER, else -> SERVE.
  - Scores never wrap; increments stop at WIN_SCORE.
- OVER: GAME_OVER=1, SEL=11.
  - SRIN = 8'hF0 if left won, 8'h0F if right won.
  - START -> scores cleared, server=LEFT, GAME_OVER=0, -> SERVE.
- START is ignored in SERVE, MOVE and POINT.
- CLEAR mid-rally returns to IDLE within one cycle; lamps are dark from the next cycle.

Timing:
- TICK at cycle n -> SEL active in cycle n+1 -> SROUT updated at the edge ending n+1.
- SROUT is next sampled no earlier than n+2, which the TICK spacing guarantees.

Decomposition:
- lampball_pkg holds:
  - state enum (IDLE, SERVE, MOVE, POINT, OVER);
  - SEL_HOLD/SEL_RIGHT/SEL_LEFT/SEL_LOAD constants;
  - LAMP_LEFT=8'h80, LAMP_RIGHT=8'h01, WIN_L_PATTERN=8'hF0, WIN_R_PATTERN=8'h0F.
- Sub-module btn_edge: a registered rising-edge detector with synchronous clear, instantiated twice (left, right).

Test Plan:
- Reset then START: SEL=11, SRIN=8'h80. BTN_L press, then 7 TICKs: SROUT model walks 80->40->...->01, and SEL shows exactly one 01 cycle per TICK.
- Ball at 8'h01, BTN_R press -> no shift on that cycle. The next TICK gives SEL=10 and SROUT=8'h02. Scores stay 0/0.
- Ball at 8'h01, TICK with no press -> SCORE_L=1, SRIN=8'h00. Then SERVE with SRIN=8'h01 (right serves).
- Ball at 8'h08 moving right, BTN_R press -> fault, SCORE_L increments. BTN_L pressed during the same rally is ignored.
- Ball at 8'h01, BTN_R press coincident with TICK -> return wins, no score change.
- WIN_SCORE=2: left wins two points -> GAME_OVER=1, SRIN=8'hF0. START clears scores and enters SERVE. CLEAR mid-MOVE -> IDLE next cycle, SEL=11, SRIN=00, scores 0.
